// File: rtl/nw_traceback_ctrl_pkg.sv
// Shared definitions for the Needleman-Wunsch traceback sequencer:
// sizing, direction codes, gap symbol and FSM state encoding.
package nw_pkg;

    localparam int N       = 128;
    localparam int BitAddr = $clog2(N);
    localparam int IDX_W   = BitAddr + 1;  // holds 0..N
    localparam int AL_W    = BitAddr + 2;  // holds 0..2N

    localparam logic [1:0] DIR_DIAG = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;  // gap in B
    localparam logic [1:0] DIR_LEFT = 2'b10;  // gap in A

    localparam logic [2:0] GAP = 3'b100;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        STEP  = 2'b10,
        DONE  = 2'b11
    } tb_state_t;

endpackage

// File: rtl/nw_traceback_ctrl_if.sv
// Bus bundle between the traceback sequencer and its host / RAMs.
// master: host side (drives start, lengths and RAM read data).
// slave : sequencer side.
interface nw_traceback_ctrl_if;
    import nw_pkg::*;

    logic             start;
    logic [IDX_W-1:0] len_a;
    logic [IDX_W-1:0] len_b;

    logic [IDX_W-1:0] dir_i;
    logic [IDX_W-1:0] dir_j;
    logic [1:0]       dir_data;

    logic [IDX_W-1:0] seqA_addr;
    logic [IDX_W-1:0] seqB_addr;
    logic [2:0]       seqA_data;
    logic [2:0]       seqB_data;

    logic             en_traceB;
    logic [AL_W-1:0]  al_addr;
    logic [2:0]       al_a_data;
    logic [2:0]       al_b_data;

    logic [AL_W-1:0]  al_len;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, len_a, len_b, dir_data, seqA_data, seqB_data,
        input  dir_i, dir_j, seqA_addr, seqB_addr,
               en_traceB, al_addr, al_a_data, al_b_data,
               al_len, busy, done, err
    );

    modport slave (
        input  start, len_a, len_b, dir_data, seqA_data, seqB_data,
        output dir_i, dir_j, seqA_addr, seqB_addr,
               en_traceB, al_addr, al_a_data, al_b_data,
               al_len, busy, done, err
    );

endinterface

// File: rtl/nw_tb_decode.sv
// Combinational move decode for one traceback step: resolves forced
// moves on the matrix border and builds the aligned symbol pair.
module nw_tb_decode
    import nw_pkg::*;
(
    input  logic       i_zero,
    input  logic       j_zero,
    input  logic [1:0] dir_data,
    input  logic [2:0] seqA_data,
    input  logic [2:0] seqB_data,
    output logic [1:0] move,
    output logic [2:0] al_a_data,
    output logic [2:0] al_b_data,
    output logic       wr_valid,
    output logic       illegal
);

    // Border cells force the move; interior cells follow the direction RAM.
    always_comb begin
        move      = dir_data;
        al_a_data = '0;
        al_b_data = '0;
        wr_valid  = 1'b0;
        illegal   = 1'b0;
        if (i_zero) begin
            move = DIR_LEFT;
        end else if (j_zero) begin
            move = DIR_UP;
        end
        case (move)
            DIR_DIAG: begin
                al_a_data = seqA_data;
                al_b_data = seqB_data;
                wr_valid  = 1'b1;
            end
            DIR_UP: begin
                al_a_data = seqA_data;
                al_b_data = GAP;
                wr_valid  = 1'b1;
            end
            DIR_LEFT: begin
                al_a_data = GAP;
                al_b_data = seqB_data;
                wr_valid  = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/nw_traceback_ctrl.sv
// Traceback sequencer: walks the direction RAM from (len_a, len_b) to
// (0,0), two cycles per aligned column (FETCH drives addresses, STEP
// consumes the registered RAM data and writes one aligned column).
// Aligned columns are written last-first, index 0 = final column.
module nw_traceback_ctrl
    import nw_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    nw_traceback_ctrl_if.slave bus
);

    tb_state_t        state, state_nxt;
    logic [IDX_W-1:0] i_q, i_nxt;
    logic [IDX_W-1:0] j_q, j_nxt;
    logic [AL_W-1:0]  k_q, k_nxt;
    logic [AL_W-1:0]  al_len_q, al_len_nxt;
    logic             err_q, err_nxt;

    logic [1:0]       move;
    logic [2:0]       dec_a, dec_b;
    logic             wr_valid, illegal;
    logic             walking;
    logic             wr_en;

    nw_tb_decode u_decode (
        .i_zero    (i_q == '0),
        .j_zero    (j_q == '0),
        .dir_data  (bus.dir_data),
        .seqA_data (bus.seqA_data),
        .seqB_data (bus.seqB_data),
        .move      (move),
        .al_a_data (dec_a),
        .al_b_data (dec_b),
        .wr_valid  (wr_valid),
        .illegal   (illegal)
    );

    // State, cell indices, column counter and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            al_len_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            i_q      <= i_nxt;
            j_q      <= j_nxt;
            k_q      <= k_nxt;
            al_len_q <= al_len_nxt;
            err_q    <= err_nxt;
        end
    end

    // Next-state logic; al_len is loaded on entry to DONE so it is valid with done.
    always_comb begin
        state_nxt  = state;
        i_nxt      = i_q;
        j_nxt      = j_q;
        k_nxt      = k_q;
        al_len_nxt = al_len_q;
        err_nxt    = err_q;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    i_nxt      = bus.len_a;
                    j_nxt      = bus.len_b;
                    k_nxt      = '0;
                    al_len_nxt = '0;
                    err_nxt    = 1'b0;
                    if (bus.len_a == '0 && bus.len_b == '0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = FETCH;
                    end
                end
            end
            FETCH: state_nxt = STEP;
            STEP: begin
                if (illegal) begin
                    err_nxt    = 1'b1;
                    al_len_nxt = k_q;
                    state_nxt  = DONE;
                end else if (wr_valid) begin
                    if (move != DIR_LEFT) i_nxt = i_q - IDX_W'(1);
                    if (move != DIR_UP)   j_nxt = j_q - IDX_W'(1);
                    k_nxt = k_q + AL_W'(1);
                    if (i_nxt == '0 && j_nxt == '0) begin
                        al_len_nxt = k_nxt;
                        state_nxt  = DONE;
                    end else begin
                        state_nxt = FETCH;
                    end
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Addresses stay valid through FETCH and STEP so RAM data lines up in STEP.
    assign walking       = (state == FETCH) || (state == STEP);
    assign bus.dir_i     = walking ? i_q : '0;
    assign bus.dir_j     = walking ? j_q : '0;
    assign bus.seqA_addr = walking ? i_q - IDX_W'(1) : '0;
    assign bus.seqB_addr = walking ? j_q - IDX_W'(1) : '0;

    assign wr_en         = (state == STEP) && wr_valid;
    assign bus.en_traceB = wr_en;
    assign bus.al_addr   = wr_en ? k_q   : '0;
    assign bus.al_a_data = wr_en ? dec_a : '0;
    assign bus.al_b_data = wr_en ? dec_b : '0;

    assign bus.al_len    = al_len_q;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.err       = err_q;

endmodule

// File: tb/tb_nw_traceback_ctrl.sv
// Directed bench for nw_traceback_ctrl: RAM models with one-cycle read
// latency, capture of aligned-RAM writes, hand-computed expectations.
module tb_nw_traceback_ctrl;
    import nw_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nw_traceback_ctrl_if bus();

    nw_traceback_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [1:0] dmat [0:N][0:N];
    logic [2:0] seqa [0:N-1];
    logic [2:0] seqb [0:N-1];

    // Synchronous-read RAM models
    always @(posedge clk) begin
        bus.dir_data  <= dmat[bus.dir_i][bus.dir_j];
        bus.seqA_data <= seqa[bus.seqA_addr[BitAddr-1:0]];
        bus.seqB_data <= seqb[bus.seqB_addr[BitAddr-1:0]];
    end

    int         ncap;
    logic [8:0] cap_addr [0:15];
    logic [2:0] cap_a    [0:15];
    logic [2:0] cap_b    [0:15];

    // Aligned-RAM write capture
    always @(negedge clk) begin
        if (bus.en_traceB === 1'b1) begin
            if (ncap < 16) begin
                cap_addr[ncap] <= bus.al_addr;
                cap_a[ncap]    <= bus.al_a_data;
                cap_b[ncap]    <= bus.al_b_data;
            end
            ncap <= ncap + 1;
        end
    end

    int n_chk  = 0;
    int n_fail = 0;
    int cyc, fi, fj, fa, fb;
    logic [2:0] ea [0:7];
    logic [2:0] eb [0:7];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill_dir(input logic [1:0] v);
        for (int r = 0; r <= N; r++)
            for (int c = 0; c <= N; c++)
                dmat[r][c] = v;
    endtask

    // Start a traceback and wait (bounded) for done; cyc counts the start
    // cycle through the DONE cycle. poke>0 pulses start while busy.
    task automatic run(input int la, input int lb, input int poke);
        ncap = 0;
        @(negedge clk);
        bus.len_a = la[IDX_W-1:0];
        bus.len_b = lb[IDX_W-1:0];
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        fi = int'(bus.dir_i);
        fj = int'(bus.dir_j);
        fa = int'(bus.seqA_addr);
        fb = int'(bus.seqB_addr);
        cyc = 1;
        forever begin
            cyc++;
            if (bus.done === 1'b1) break;
            if (cyc > 600) begin
                chk("timeout_done", 32'd0, 32'd1);
                break;
            end
            if (poke != 0 && cyc == poke) begin
                bus.start = 1'b1;
                bus.len_a = 8'd7;
                bus.len_b = 8'd7;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        chk("busy_in_done", bus.busy, 1);
    endtask

    task automatic chk_writes(input int n);
        chk("n_writes", ncap, n);
        for (int w = 0; w < n && w < 16; w++) begin
            chk($sformatf("wr_addr[%0d]", w), cap_addr[w], w);
            chk($sformatf("wr_a[%0d]", w), cap_a[w], ea[w]);
            chk($sformatf("wr_b[%0d]", w), cap_b[w], eb[w]);
        end
    endtask

    task automatic chk_after_done();
        @(posedge clk); #1;
        chk("busy_after", bus.busy, 0);
        chk("done_pulse", bus.done, 0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.len_a = '0;
        bus.len_b = '0;
        ncap = 0;
        for (int x = 0; x < N; x++) begin
            seqa[x] = 3'(x % 4);
            seqb[x] = 3'(3 - (x % 4));
        end
        fill_dir(2'b00);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_en", bus.en_traceB, 0);
        chk("rst_al_addr", bus.al_addr, 0);
        chk("rst_al_len", bus.al_len, 0);
        chk("rst_dir_i", bus.dir_i, 0);
        chk("rst_seqA_addr", bus.seqA_addr, 0);
        chk("rst_al_a", bus.al_a_data, 0);
        @(negedge clk);
        rst = 1'b0;

        // 4x4 all-diagonal
        ea[0] = 3; eb[0] = 0;
        ea[1] = 2; eb[1] = 1;
        ea[2] = 1; eb[2] = 2;
        ea[3] = 0; eb[3] = 3;
        run(4, 4, 0);
        chk("diag_cycles", cyc, 10);
        chk("diag_al_len", bus.al_len, 4);
        chk("diag_err", bus.err, 0);
        chk("diag_dir_i", fi, 4);
        chk("diag_dir_j", fj, 4);
        chk("diag_seqA_addr", fa, 3);
        chk("diag_seqB_addr", fb, 3);
        chk_writes(4);
        chk_after_done();
        chk("diag_al_len_held", bus.al_len, 4);

        // 3x0: forced UP, direction RAM poisoned with illegal codes
        fill_dir(2'b11);
        ea[0] = 2; eb[0] = 3'b100;
        ea[1] = 1; eb[1] = 3'b100;
        ea[2] = 0; eb[2] = 3'b100;
        run(3, 0, 0);
        chk("up_cycles", cyc, 8);
        chk("up_al_len", bus.al_len, 3);
        chk("up_err", bus.err, 0);
        chk("up_dir_i", fi, 3);
        chk_writes(3);
        chk_after_done();

        // 2x3 path LEFT, DIAG, UP, then forced LEFT on row 0
        fill_dir(2'b11);
        dmat[2][3] = 2'b10;
        dmat[2][2] = 2'b00;
        dmat[1][1] = 2'b01;
        ea[0] = 3'b100; eb[0] = 1;
        ea[1] = 1;      eb[1] = 2;
        ea[2] = 0;      eb[2] = 3'b100;
        ea[3] = 3'b100; eb[3] = 3;
        run(2, 3, 0);
        chk("mix_cycles", cyc, 10);
        chk("mix_al_len", bus.al_len, 4);
        chk("mix_err", bus.err, 0);
        chk_writes(4);
        chk_after_done();

        // 3x3 with illegal code at the second step
        fill_dir(2'b11);
        dmat[3][3] = 2'b00;
        ea[0] = 2; eb[0] = 1;
        run(3, 3, 0);
        chk("ill_cycles", cyc, 6);
        chk("ill_err", bus.err, 1);
        chk("ill_al_len", bus.al_len, 1);
        chk_writes(1);
        chk_after_done();
        chk("ill_err_sticky", bus.err, 1);

        // 0x0: immediate done, clears err
        run(0, 0, 0);
        chk("zero_cycles", cyc, 2);
        chk("zero_al_len", bus.al_len, 0);
        chk("zero_err_cleared", bus.err, 0);
        chk("zero_n_writes", ncap, 0);
        chk_after_done();

        // Asynchronous reset during STEP of a 5x5 run
        fill_dir(2'b00);
        ncap = 0;
        @(negedge clk);
        bus.len_a = 8'd5;
        bus.len_b = 8'd5;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        chk("mid_en_step", bus.en_traceB, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_en", bus.en_traceB, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_al_addr", bus.al_addr, 0);
        chk("mid_rst_dir_i", bus.dir_i, 0);
        chk("mid_rst_al_b", bus.al_b_data, 0);
        @(negedge clk);
        rst = 1'b0;

        // 2x2 diagonal with a start pulse while busy
        ea[0] = 1; eb[0] = 2;
        ea[1] = 0; eb[1] = 3;
        run(2, 2, 3);
        chk("poke_cycles", cyc, 6);
        chk("poke_al_len", bus.al_len, 2);
        chk_writes(2);
        chk_after_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
